// File: rtl/max_star_tree_pkg.sv
// Shared constants for the max / max* reduction tree: default metric width,
// mode encodings and the max* correction lookup.
package max_star_tree_pkg;

  localparam int WIDTH_DEFAULT = 10;

  localparam int MODE_MAX_LOG  = 0;
  localparam int MODE_MAX_STAR = 1;

  // Correction is a step approximation of ln(1 + e^-|d|) in LSB units.
  localparam int unsigned CORR_TH_ZERO  = 0;
  localparam int unsigned CORR_TH_SMALL = 2;
  localparam int unsigned CORR_TH_MID   = 5;

  localparam logic [1:0] CORR_VAL_ZERO  = 2'd3;
  localparam logic [1:0] CORR_VAL_SMALL = 2'd2;
  localparam logic [1:0] CORR_VAL_MID   = 2'd1;
  localparam logic [1:0] CORR_VAL_NONE  = 2'd0;

  function automatic logic [1:0] corr_lut(input logic [31:0] mag);
    if (mag == CORR_TH_ZERO)       return CORR_VAL_ZERO;
    else if (mag <= CORR_TH_SMALL) return CORR_VAL_SMALL;
    else if (mag <= CORR_TH_MID)   return CORR_VAL_MID;
    else                           return CORR_VAL_NONE;
  endfunction

endpackage

// File: rtl/max_star_tree_node.sv
// One tree node: compares two signed metrics, optionally adds the max*
// correction, and registers winner value, winner index and valid.
module max_star_node
  import max_star_tree_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int IDX_W = 3,
  parameter int MODE  = MODE_MAX_LOG
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    valid_in,
  input  logic signed [WIDTH-1:0] a_val,
  input  logic [IDX_W-1:0]        a_idx,
  input  logic signed [WIDTH-1:0] b_val,
  input  logic [IDX_W-1:0]        b_idx,
  output logic                    valid_out,
  output logic signed [WIDTH-1:0] val_out,
  output logic [IDX_W-1:0]        idx_out
);

  localparam logic [WIDTH:0] SAT_MAX = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH:0] ONE     = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0]          diff;
  logic [WIDTH:0]          mag;
  logic [WIDTH:0]          sum;
  logic                    a_wins;
  logic signed [WIDTH-1:0] win_val;
  logic [IDX_W-1:0]        win_idx;
  logic [1:0]              corr;

  logic                    valid_d, valid_q;
  logic signed [WIDTH-1:0] val_d, val_q;
  logic [IDX_W-1:0]        idx_d, idx_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    valid_d = valid_q;
    val_d   = val_q;
    idx_d   = idx_q;

    // One extra bit keeps +511 - (-512) from wrapping to a negative result.
    diff    = {a_val[WIDTH-1], a_val} - {b_val[WIDTH-1], b_val};
    a_wins  = ~diff[WIDTH];
    mag     = diff[WIDTH] ? (~diff + ONE) : diff;
    win_val = a_wins ? a_val : b_val;
    win_idx = a_wins ? a_idx : b_idx;
    corr    = (MODE == MODE_MAX_STAR) ? corr_lut(32'(mag)) : CORR_VAL_NONE;
    sum     = {win_val[WIDTH-1], win_val} + {{(WIDTH-1){1'b0}}, corr};

    if (ce) begin
      valid_d = valid_in;
      idx_d   = win_idx;
      // Correction is non-negative, so only positive overflow is possible.
      val_d   = (~sum[WIDTH] & sum[WIDTH-1]) ? SAT_MAX[WIDTH-1:0] : sum[WIDTH-1:0];
    end
  end

  // NOTE: state is updated with non-blocking assignments so all nodes sample the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      val_q   <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      val_q   <= val_d;
      idx_q   <= idx_d;
    end
  end

  assign valid_out = valid_q;
  assign val_out   = val_q;
  assign idx_out   = idx_q;

endmodule

// File: rtl/max_star_tree.sv
// Pipelined binary max / max* reduction over NUM_IN signed channels, one
// register stage per tree level, reporting the winning channel index.
module max_star_tree
  import max_star_tree_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int NUM_IN = 8,
  parameter int MODE   = MODE_MAX_LOG
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic                      in_valid,
  input  logic [NUM_IN*WIDTH-1:0]   data_in,
  output logic                      out_valid,
  output logic signed [WIDTH-1:0]   data_out_max,
  output logic [$clog2(NUM_IN)-1:0] max_index
);

  localparam int IDX_W = $clog2(NUM_IN);
  localparam int NODES = 2 * NUM_IN - 1;

  // Heap layout: node n has children 2n+1 and 2n+2, leaves sit at NUM_IN-1+i,
  // which pairs (2k, 2k+1) at the bottom and keeps every level in order.
  logic signed [WIDTH-1:0] tree_val   [NODES];
  logic [IDX_W-1:0]        tree_idx   [NODES];
  logic                    tree_valid [NODES];

  for (genvar i = 0; i < NUM_IN; i++) begin : g_leaf
    assign tree_val[NUM_IN-1+i]   = data_in[i*WIDTH +: WIDTH];
    assign tree_idx[NUM_IN-1+i]   = IDX_W'(i);
    assign tree_valid[NUM_IN-1+i] = in_valid;
  end

  for (genvar n = 0; n < NUM_IN - 1; n++) begin : g_node
    max_star_node #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W),
      .MODE  (MODE)
    ) u_node (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .valid_in  (tree_valid[2*n+1]),
      .a_val     (tree_val[2*n+1]),
      .a_idx     (tree_idx[2*n+1]),
      .b_val     (tree_val[2*n+2]),
      .b_idx     (tree_idx[2*n+2]),
      .valid_out (tree_valid[n]),
      .val_out   (tree_val[n]),
      .idx_out   (tree_idx[n])
    );
  end

  assign out_valid    = tree_valid[0];
  assign data_out_max = tree_val[0];
  assign max_index    = tree_idx[0];

endmodule

// File: tb/tb_max_star_tree.sv
// Directed and random checks of max_star_tree across sizes and both modes.
module tb_max_star_tree;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic ce  = 1'b0;

  logic              iv8 = 1'b0;
  logic [79:0]       d8  = '0;
  logic              ov8;
  logic signed [9:0] dm8;
  logic [2:0]        mi8;

  logic              iv2 = 1'b0;
  logic [19:0]       d2  = '0;
  logic              ov2;
  logic signed [9:0] dm2;
  logic [0:0]        mi2;

  logic              iv4 = 1'b0;
  logic [39:0]       d4  = '0;
  logic              ov4;
  logic signed [9:0] dm4;
  logic [1:0]        mi4;

  logic              iv16 = 1'b0;
  logic [159:0]      d16  = '0;
  logic              ov16, ov16s;
  logic signed [9:0] dm16, dm16s;
  logic [3:0]        mi16, mi16s;

  max_star_tree #(.WIDTH(10), .NUM_IN(8), .MODE(0)) dut8 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(iv8), .data_in(d8),
    .out_valid(ov8), .data_out_max(dm8), .max_index(mi8));

  max_star_tree #(.WIDTH(10), .NUM_IN(2), .MODE(1)) dut2 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(iv2), .data_in(d2),
    .out_valid(ov2), .data_out_max(dm2), .max_index(mi2));

  max_star_tree #(.WIDTH(10), .NUM_IN(4), .MODE(1)) dut4 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(iv4), .data_in(d4),
    .out_valid(ov4), .data_out_max(dm4), .max_index(mi4));

  max_star_tree #(.WIDTH(10), .NUM_IN(16), .MODE(0)) dut16 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(iv16), .data_in(d16),
    .out_valid(ov16), .data_out_max(dm16), .max_index(mi16));

  max_star_tree #(.WIDTH(10), .NUM_IN(16), .MODE(1)) dut16s (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(iv16), .data_in(d16),
    .out_valid(ov16s), .data_out_max(dm16s), .max_index(mi16s));

  // Reference: pairwise reduction in channel order with integer arithmetic.
  function automatic void ref_tree(input int n, input int mode, input int v[16],
                                   output int mv, output int mi);
    int cv[16];
    int ci[16];
    int cnt;
    int d, m, w, wi;
    for (int i = 0; i < 16; i++) begin
      cv[i] = v[i];
      ci[i] = i;
    end
    cnt = n;
    while (cnt > 1) begin
      for (int k = 0; k < cnt / 2; k++) begin
        d = cv[2*k] - cv[2*k+1];
        if (d >= 0) begin w = cv[2*k];   wi = ci[2*k];   end
        else        begin w = cv[2*k+1]; wi = ci[2*k+1]; end
        if (mode == 1) begin
          m = (d < 0) ? -d : d;
          if (m == 0)      w = w + 3;
          else if (m <= 2) w = w + 2;
          else if (m <= 5) w = w + 1;
          if (w > 511) w = 511;
        end
        cv[k] = w;
        ci[k] = wi;
      end
      cnt = cnt / 2;
    end
    mv = cv[0];
    mi = ci[0];
  endfunction

  task automatic drive8(input int v[8]);
    for (int i = 0; i < 8; i++) d8[i*10 +: 10] = 10'(v[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ce  = 1'b0;
    iv8 = 1'b1; iv2 = 1'b1; iv4 = 1'b1; iv16 = 1'b1;
    d8 = '1; d2 = '1; d4 = '1; d16 = '1;
    repeat (3) @(negedge clk);
    checks++; if (ov8 !== 1'b0)   begin failures++; $display("FAIL reset_ov8 got=%b exp=0", ov8); end
    checks++; if (dm8 !== 10'd0)  begin failures++; $display("FAIL reset_dm8 got=%0d exp=0", dm8); end
    checks++; if (mi8 !== 3'd0)   begin failures++; $display("FAIL reset_mi8 got=%0d exp=0", mi8); end
    checks++; if (ov2 !== 1'b0)   begin failures++; $display("FAIL reset_ov2 got=%b exp=0", ov2); end
    checks++; if (dm2 !== 10'd0)  begin failures++; $display("FAIL reset_dm2 got=%0d exp=0", dm2); end
    checks++; if (ov16s !== 1'b0) begin failures++; $display("FAIL reset_ov16s got=%b exp=0", ov16s); end
    rst = 1'b0;
    ce  = 1'b1;
    iv8 = 1'b0; iv2 = 1'b0; iv4 = 1'b0; iv16 = 1'b0;
    @(negedge clk);
    checks++; if (ov8 !== 1'b0) begin failures++; $display("FAIL reset_release_ov8 got=%b exp=0", ov8); end
  endtask

  task automatic test_basic_max();
    int v[8];
    v = '{5, -3, 100, 7, 0, -512, 99, 1};
    drive8(v);
    iv8 = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      iv8 = 1'b0;
      if (c == 3) begin
        checks++; if (ov8 !== 1'b1)   begin failures++; $display("FAIL basic_ov got=%b exp=1", ov8); end
        checks++; if (dm8 !== 10'd100) begin failures++; $display("FAIL basic_max got=%0d exp=100", dm8); end
        checks++; if (mi8 !== 3'd2)   begin failures++; $display("FAIL basic_idx got=%0d exp=2", mi8); end
      end else begin
        checks++; if (ov8 !== 1'b0) begin failures++; $display("FAIL basic_ov_c%0d got=%b exp=0", c, ov8); end
      end
    end
  endtask

  task automatic test_extremes_ties();
    int vecs[4][8];
    int ev[4];
    int ei[4];
    vecs = '{'{-512, -512, -512, -512, -512, -512, -512, 511},
             '{42, 42, 42, 42, 42, 42, 42, 42},
             '{511, -512, -512, -512, -512, -512, -512, -512},
             '{-512, -512, -512, -512, -512, -511, -512, -512}};
    ev = '{511, 42, 511, -511};
    ei = '{7, 0, 0, 5};
    drive8(vecs[0]);
    iv8 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c >= 3 && c - 3 < 4) begin
        checks++; if (ov8 !== 1'b1) begin failures++; $display("FAIL ext_ov%0d got=%b exp=1", c - 3, ov8); end
        checks++; if (dm8 !== 10'(ev[c-3])) begin
          failures++; $display("FAIL ext_max%0d got=%0d exp=%0d", c - 3, dm8, ev[c-3]);
        end
        checks++; if (mi8 !== 3'(ei[c-3])) begin
          failures++; $display("FAIL ext_idx%0d got=%0d exp=%0d", c - 3, mi8, ei[c-3]);
        end
      end else begin
        checks++; if (ov8 !== 1'b0) begin failures++; $display("FAIL ext_idle_c%0d got=%b exp=0", c, ov8); end
      end
      if (c < 4) drive8(vecs[c]);
      else       iv8 = 1'b0;
    end
  endtask

  task automatic test_mode1_correction();
    int a[8];
    int b[8];
    int ev[8];
    int ei[8];
    a  = '{10, 10, 10, 510, 8,   -512, 511, -5};
    b  = '{10, 8,  4,  510, 10,  511,  511, -8};
    ev = '{13, 12, 10, 511, 12,  511,  511, -4};
    ei = '{0,  0,  0,  0,   1,   1,    0,   0};
    for (int t = 0; t <= 8; t++) begin
      if (t > 0) begin
        checks++; if (ov2 !== 1'b1) begin failures++; $display("FAIL m1_ov%0d got=%b exp=1", t - 1, ov2); end
        checks++; if (dm2 !== 10'(ev[t-1])) begin
          failures++; $display("FAIL m1_val%0d got=%0d exp=%0d", t - 1, dm2, ev[t-1]);
        end
        checks++; if (mi2 !== 1'(ei[t-1])) begin
          failures++; $display("FAIL m1_idx%0d got=%0d exp=%0d", t - 1, mi2, ei[t-1]);
        end
      end
      if (t < 8) begin
        d2  = {10'(b[t]), 10'(a[t])};
        iv2 = 1'b1;
      end else begin
        iv2 = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL m1_drain got=%b exp=0", ov2); end
  endtask

  task automatic test_stream_stall();
    int vecs[6][8];
    int ev[6];
    int ei[6];
    int got, fed;
    logic prev_ce, ce_now;
    logic snap_ov;
    logic [9:0] snap_dm;
    logic [2:0] snap_mi;
    vecs = '{'{1, 2, 3, 4, 5, 6, 7, 8},
             '{-1, -2, -3, -4, -5, -6, -7, -8},
             '{0, 0, 0, 300, 0, 0, 0, 0},
             '{-100, -50, -200, -7, -7, -300, -9, -512},
             '{0, 0, 0, 0, 0, 0, 511, 0},
             '{-512, -512, -512, -512, -512, -512, -512, -512}};
    ev = '{8, -1, 300, -7, 511, -512};
    ei = '{7, 0, 3, 3, 6, 0};
    got = 0; fed = 0; prev_ce = 1'b1;
    snap_ov = ov8; snap_dm = dm8; snap_mi = mi8;
    for (int c = 0; c < 20; c++) begin
      if (!prev_ce) begin
        checks++; if (ov8 !== snap_ov || dm8 !== snap_dm || mi8 !== snap_mi) begin
          failures++;
          $display("FAIL stall_hold_c%0d got=%b/%0d/%0d exp=%b/%0d/%0d", c, ov8, dm8, mi8, snap_ov, $signed(snap_dm), snap_mi);
        end
      end else if (ov8 === 1'b1) begin
        checks++;
        if (got >= 6) begin
          failures++; $display("FAIL stream_extra got=%0d exp=none", dm8);
        end else if (dm8 !== 10'(ev[got]) || mi8 !== 3'(ei[got])) begin
          failures++; $display("FAIL stream_out%0d got=%0d/%0d exp=%0d/%0d", got, dm8, mi8, ev[got], ei[got]);
        end
        got++;
      end
      snap_ov = ov8; snap_dm = dm8; snap_mi = mi8;
      ce_now = !(c >= 4 && c <= 7);
      ce = ce_now;
      if (!ce_now) begin
        iv8 = 1'b1;
        for (int i = 0; i < 8; i++) d8[i*10 +: 10] = 10'd400;
      end else if (fed < 6) begin
        drive8(vecs[fed]);
        iv8 = 1'b1;
        fed++;
      end else begin
        iv8 = 1'b0;
      end
      prev_ce = ce_now;
      @(negedge clk);
    end
    checks++; if (got != 6) begin failures++; $display("FAIL stream_count got=%0d exp=6", got); end
    ce = 1'b1;
    iv8 = 1'b0;
  endtask

  task automatic test_reset_midflight();
    int va[8];
    int vb[8];
    int vx[8];
    int vc[8];
    va = '{1, 2, 3, 4, 5, 6, 7, 200};
    vb = '{250, 0, 0, 0, 0, 0, 0, 0};
    vx = '{0, 0, 0, 0, 300, 0, 0, 0};
    vc = '{-20, -30, -40, -10, -50, -60, -70, -80};
    drive8(va);
    iv8 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 6) begin
        checks++; if (ov8 !== 1'b1) begin failures++; $display("FAIL rstmid_ov got=%b exp=1", ov8); end
        checks++; if (dm8 !== -10'sd10) begin failures++; $display("FAIL rstmid_max got=%0d exp=-10", dm8); end
        checks++; if (mi8 !== 3'd3) begin failures++; $display("FAIL rstmid_idx got=%0d exp=3", mi8); end
      end else begin
        checks++; if (ov8 !== 1'b0) begin failures++; $display("FAIL rstmid_idle_c%0d got=%b exp=0", c, ov8); end
      end
      rst = 1'b0;
      case (c)
        1: drive8(vb);
        2: begin rst = 1'b1; drive8(vx); iv8 = 1'b1; end
        3: drive8(vc);
        default: iv8 = 1'b0;
      endcase
    end
  endtask

  task automatic test_random();
    int lat[5];
    int nn[5];
    int md[5];
    int hv[5][32];
    int hm[5][32];
    int hi[5][32];
    int ov_o[5];
    int dm_o[5];
    int mi_o[5];
    int vals[16];
    int ev, mv, mi, base, sel, shown;
    logic iv;
    lat = '{3, 1, 2, 4, 4};
    nn  = '{8, 2, 4, 16, 16};
    md  = '{0, 1, 1, 0, 1};
    shown = 0;
    rst = 1'b1; ce = 1'b1;
    iv8 = 1'b0; iv2 = 1'b0; iv4 = 1'b0; iv16 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10004; k++) begin
      ov_o = '{int'(ov8), int'(ov2), int'(ov4), int'(ov16), int'(ov16s)};
      dm_o = '{int'(dm8), int'(dm2), int'(dm4), int'(dm16), int'(dm16s)};
      mi_o = '{int'(mi8), int'(mi2), int'(mi4), int'(mi16), int'(mi16s)};
      for (int d = 0; d < 5; d++) begin
        ev = (k >= lat[d]) ? hv[d][(k - lat[d]) % 32] : 0;
        checks++;
        if (ov_o[d] != ev || (ev == 1 && (dm_o[d] != hm[d][(k - lat[d]) % 32] ||
                                          mi_o[d] != hi[d][(k - lat[d]) % 32]))) begin
          failures++;
          if (shown < 20) begin
            shown++;
            $display("FAIL rand_dut%0d_k%0d got=%0d/%0d/%0d exp_valid=%0d", d, k, ov_o[d], dm_o[d], mi_o[d], ev);
          end
        end
      end
      iv = (k < 10000) && ($urandom_range(0, 3) != 0);
      sel  = int'($urandom_range(0, 2));
      base = (sel == 2) ? 505 : int'($urandom_range(0, 1023)) - 512;
      for (int i = 0; i < 16; i++) begin
        if (sel == 0) vals[i] = int'($urandom_range(0, 1023)) - 512;
        else          vals[i] = base + int'($urandom_range(0, 12)) - 6;
        if (vals[i] > 511)  vals[i] = 511;
        if (vals[i] < -512) vals[i] = -512;
      end
      for (int i = 0; i < 8; i++)  d8[i*10 +: 10]  = 10'(vals[i]);
      for (int i = 0; i < 2; i++)  d2[i*10 +: 10]  = 10'(vals[i]);
      for (int i = 0; i < 4; i++)  d4[i*10 +: 10]  = 10'(vals[i]);
      for (int i = 0; i < 16; i++) d16[i*10 +: 10] = 10'(vals[i]);
      iv8 = iv; iv2 = iv; iv4 = iv; iv16 = iv;
      for (int d = 0; d < 5; d++) begin
        ref_tree(nn[d], md[d], vals, mv, mi);
        hv[d][k % 32] = int'(iv);
        hm[d][k % 32] = mv;
        hi[d][k % 32] = mi;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "simulation timeout");
  end

  initial begin
    test_reset();
    test_basic_max();
    test_extremes_ties();
    test_mode1_correction();
    test_stream_stall();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
